// File: rtl/serial_frame_pkg.sv
// Shared constants and state encoding for the serial frame transmitter.
// Imported by the top level and by the bench for the debug state port.
package serial_frame_pkg;

    localparam logic [7:0] MAGIC         = 8'hFF;
    localparam int         MODE_FREQ_BIT = 1;
    localparam int         MODE_TIME_BIT = 0;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MAGIC = 3'd1,
        S_HDR   = 3'd2,
        S_FREQ  = 3'd3,
        S_TIME  = 3'd4,
        S_CSUM  = 3'd5,
        S_FIN   = 3'd6
    } frame_state_t;

endpackage

// File: rtl/serial_frame_tx_if.sv
// Byte stream link from the frame serializer to the UART transmitter.
// A byte moves on a rising clock edge where tx_valid & tx_ready. Once tx_valid
// is raised it stays high and tx_data holds until that transfer happens.
interface serial_frame_tx_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/serial_frame_tx_byte_shifter.sv
// Holds one DW-bit word and presents it a byte at a time, LSB first.
// A load takes priority over a shift presented in the same cycle.
module frame_byte_shifter #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_load,
    input  logic [DW-1:0] i_word,
    input  logic          i_shift,
    output logic [7:0]    o_byte,
    output logic          o_last
);

    localparam int NB = DW / 8;
    localparam int CW = $clog2(NB + 1);

    logic [DW-1:0] r_word;
    logic [CW-1:0] r_cnt;

    // r_cnt counts bytes still to be sent from the current word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word <= '0;
            r_cnt  <= '0;
        end else if (i_load) begin
            r_word <= i_word;
            r_cnt  <= CW'(NB);
        end else if (i_shift && (r_cnt != '0)) begin
            r_word <= r_word >> 8;
            r_cnt  <= r_cnt - CW'(1);
        end
    end

    assign o_byte = r_word[7:0];
    assign o_last = (r_cnt == CW'(1));

endmodule

// File: rtl/serial_frame_tx.sv
// Frequency-meter frame serializer: magic, header, selected words LSB first.
// Define SERIAL_FRAME_CSUM_EN to append an 8-bit additive checksum byte.
module serial_frame_tx
    import serial_frame_pkg::*;
#(
    parameter int NF = 2,
    parameter int NT = 10,
    parameter int DW = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [1:0]         mode,
    input  logic [NF*DW-1:0]   fval,
    input  logic [NT*DW-1:0]   tval,
    output logic               busy,
    output logic               done,
    output frame_state_t       o_dbg_state,
    serial_frame_tx_if.master  tx
);

    localparam int NMAX = (NF > NT) ? NF : NT;
    localparam int IW   = $clog2(NMAX + 1);

    frame_state_t     r_state, w_next, w_tail;
    logic [1:0]       r_mode;
    logic [NF*DW-1:0] r_fval;
    logic [NT*DW-1:0] r_tval;
    logic [IW-1:0]    r_widx, w_widx_next;
    logic             r_busy, r_done;
    logic             w_xfer, w_load, w_last, w_shift_f, w_shift_t;
    logic [DW-1:0]    w_load_word;
    logic [7:0]       w_byte, w_tx_data;

`ifdef SERIAL_FRAME_CSUM_EN
    logic [7:0] r_csum;
    assign w_tail = S_CSUM;
`else
    assign w_tail = S_FIN;
`endif

    assign w_xfer = r_busy & tx.tx_ready;

    // Snapshots are consumed from the top word down, so word NF-1/NT-1 goes first
    always_comb begin
        w_next      = r_state;
        w_widx_next = r_widx;
        w_load      = 1'b0;
        w_load_word = '0;
        w_shift_f   = 1'b0;
        w_shift_t   = 1'b0;
        case (r_state)
            S_IDLE:  if (start) w_next = S_MAGIC;
            S_MAGIC: if (w_xfer) w_next = S_HDR;
            S_HDR: if (w_xfer) begin
                if (r_mode[MODE_FREQ_BIT]) begin
                    w_next = S_FREQ;
                    w_load = 1'b1;
                    w_load_word = r_fval[NF*DW-1 -: DW];
                    w_shift_f = 1'b1;
                    w_widx_next = IW'(NF - 1);
                end else if (r_mode[MODE_TIME_BIT]) begin
                    w_next = S_TIME;
                    w_load = 1'b1;
                    w_load_word = r_tval[NT*DW-1 -: DW];
                    w_shift_t = 1'b1;
                    w_widx_next = IW'(NT - 1);
                end else begin
                    w_next = w_tail;
                end
            end
            S_FREQ: if (w_xfer && w_last) begin
                if (r_widx != '0) begin
                    w_load = 1'b1;
                    w_load_word = r_fval[NF*DW-1 -: DW];
                    w_shift_f = 1'b1;
                    w_widx_next = r_widx - IW'(1);
                end else if (r_mode[MODE_TIME_BIT]) begin
                    w_next = S_TIME;
                    w_load = 1'b1;
                    w_load_word = r_tval[NT*DW-1 -: DW];
                    w_shift_t = 1'b1;
                    w_widx_next = IW'(NT - 1);
                end else begin
                    w_next = w_tail;
                end
            end
            S_TIME: if (w_xfer && w_last) begin
                if (r_widx != '0) begin
                    w_load = 1'b1;
                    w_load_word = r_tval[NT*DW-1 -: DW];
                    w_shift_t = 1'b1;
                    w_widx_next = r_widx - IW'(1);
                end else begin
                    w_next = w_tail;
                end
            end
            S_CSUM:  if (w_xfer) w_next = S_FIN;
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_mode  <= '0;
            r_fval  <= '0;
            r_tval  <= '0;
            r_widx  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_widx  <= w_widx_next;
            r_busy  <= (w_next != S_IDLE) && (w_next != S_FIN);
            r_done  <= (w_next == S_FIN);
            if (r_state == S_IDLE && start) begin
                r_mode <= mode;
                r_fval <= fval;
                r_tval <= tval;
            end
            if (w_shift_f) r_fval <= r_fval << DW;
            if (w_shift_t) r_tval <= r_tval << DW;
        end
    end

`ifdef SERIAL_FRAME_CSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_csum <= '0;
        end else if (r_state == S_IDLE && start) begin
            r_csum <= '0;
        end else if (w_xfer && (r_state == S_HDR || r_state == S_FREQ || r_state == S_TIME)) begin
            r_csum <= r_csum + w_tx_data;
        end
    end
`endif

    frame_byte_shifter #(.DW(DW)) u_shifter (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load),
        .i_word  (w_load_word),
        .i_shift (w_xfer && (r_state == S_FREQ || r_state == S_TIME)),
        .o_byte  (w_byte),
        .o_last  (w_last)
    );

    always_comb begin
        w_tx_data = 8'h00;
        case (r_state)
            S_MAGIC:         w_tx_data = MAGIC;
            S_HDR:           w_tx_data = {6'b0, r_mode};
            S_FREQ, S_TIME:  w_tx_data = w_byte;
`ifdef SERIAL_FRAME_CSUM_EN
            S_CSUM:          w_tx_data = r_csum;
`endif
            default:         w_tx_data = 8'h00;
        endcase
    end

    assign tx.tx_data  = w_tx_data;
    assign tx.tx_valid = r_busy;
    assign busy        = r_busy;
    assign done        = r_done;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: reference frames are built from the frame format
// and compared byte by byte by a monitor that watches the byte stream.
module tb_serial_frame_tx;
  import serial_frame_pkg::*;

  localparam int NF = 2;
  localparam int NT = 10;
  localparam int DW = 32;
  localparam int NB = DW / 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [1:0]       mode = 2'b00;
  logic [NF*DW-1:0] fval = '0;
  logic [NT*DW-1:0] tval = '0;
  logic             busy, done;
  frame_state_t     dbg_state;

  serial_frame_tx_if tx_if ();

  serial_frame_tx #(.NF(NF), .NT(NT), .DW(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .mode        (mode),
    .fval        (fval),
    .tval        (tval),
    .busy        (busy),
    .done        (done),
    .o_dbg_state (dbg_state),
    .tx          (tx_if.master)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];
  int xfer_cnt = 0;
  bit done_seen = 1'b0;
  bit ready_rand = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // reference model: frame laid out directly from the format description
  function automatic int model_frame(input logic [1:0] m, input logic [NF*DW-1:0] f,
                                     input logic [NT*DW-1:0] t);
    logic [7:0] bytes[$];
    logic [DW-1:0] w;
    logic [7:0] sum;
    bytes.push_back(8'hFF);
    bytes.push_back({6'b0, m});
    if (m[1])
      for (int i = NF - 1; i >= 0; i--) begin
        w = DW'(f >> (i * DW));
        for (int b = 0; b < NB; b++) bytes.push_back(8'(w >> (b * 8)));
      end
    if (m[0])
      for (int i = NT - 1; i >= 0; i--) begin
        w = DW'(t >> (i * DW));
        for (int b = 0; b < NB; b++) bytes.push_back(8'(w >> (b * 8)));
      end
`ifdef SERIAL_FRAME_CSUM_EN
    sum = 8'h00;
    for (int k = 1; k < bytes.size(); k++) sum = sum + bytes[k];
    bytes.push_back(sum);
`endif
    foreach (bytes[k]) exp_q.push_back(bytes[k]);
    return bytes.size();
  endfunction

  function automatic logic [NF*DW-1:0] rand_f();
    logic [NF*DW-1:0] v = '0;
    for (int i = 0; i < NF * DW / 32; i++) v = (v << 32) | (NF*DW)'($urandom());
    return v;
  endfunction

  function automatic logic [NT*DW-1:0] rand_t();
    logic [NT*DW-1:0] v = '0;
    for (int i = 0; i < NT * DW / 32; i++) v = (v << 32) | (NT*DW)'($urandom());
    return v;
  endfunction

  // sink: ready either held high or randomly stalled
  initial begin
    tx_if.tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      tx_if.tx_ready = ready_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // scoreboard monitor
  logic [7:0] prev_data = 8'h00;
  bit prev_stall = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 64'(tx_if.tx_valid), 64'(1));
        check("hold_data", 64'(tx_if.tx_data), 64'(prev_data));
      end
      if (tx_if.tx_valid && tx_if.tx_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_byte: got %0h expected no byte", tx_if.tx_data);
        end else begin
          check($sformatf("byte%0d", xfer_cnt), 64'(tx_if.tx_data), 64'(exp_q.pop_front()));
        end
        xfer_cnt++;
      end
      prev_stall = tx_if.tx_valid && !tx_if.tx_ready;
      prev_data  = tx_if.tx_data;
      if (done) done_seen = 1'b1;
    end
  end

  // driver: issue one frame and wait for done; called at posedge+1
  task automatic run_frame(input logic [1:0] m, input logic [NF*DW-1:0] f,
                           input logic [NT*DW-1:0] t, input bit stall, input bit disturb);
    int len;
    int cyc;
    ready_rand = stall;
    mode = m;
    fval = f;
    tval = t;
    start = 1'b1;
    len = model_frame(m, f, t);
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 0;
    check("start_busy", 64'(busy), 64'(1));
    check("start_valid", 64'(tx_if.tx_valid), 64'(1));
    check("start_byte", 64'(tx_if.tx_data), 64'(8'hFF));
    while (!done && cyc < 3000) begin
      if (disturb && cyc == 4) begin
        mode = ~m;
        fval = ~f;
        tval = ~t;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    start = 1'b0;
    check("done_seen", 64'(done), 64'(1));
    // done appears L edges after the start edge, i.e. in cycle L+1
    if (!stall) check("done_latency", 64'(cyc), 64'(len));
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    check("fin_busy", 64'(busy), 64'(0));
    check("fin_valid", 64'(tx_if.tx_valid), 64'(0));
    @(posedge clk);
    #1;
    check("done_pulse", 64'(done), 64'(0));
    check("idle_after", 64'(tx_if.tx_valid), 64'(0));
    exp_q.delete();
  endtask

  logic [NF*DW-1:0] keep_f;
  logic [NT*DW-1:0] keep_t;
  int cyc;
  int dummy_len;

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_valid", 64'(tx_if.tx_valid), 64'(0));
    check("rst_data", 64'(tx_if.tx_data), 64'(0));
    check("rst_state", 64'(dbg_state), 64'(S_IDLE));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_frame(2'b00, rand_f(), rand_t(), 1'b0, 1'b0);
    run_frame(2'b10, {32'h11223344, 32'h00000001}, rand_t(), 1'b0, 1'b0);
    keep_f = rand_f();
    keep_t = rand_t();
    run_frame(2'b11, keep_f, keep_t, 1'b0, 1'b0);
    run_frame(2'b11, keep_f, keep_t, 1'b1, 1'b0);
    run_frame(2'b01, rand_f(), rand_t(), 1'b0, 1'b0);
    run_frame(2'b11, rand_f(), rand_t(), 1'b0, 1'b1);

    // reset in the middle of a frame
    ready_rand = 1'b0;
    xfer_cnt = 0;
    mode = 2'b11;
    fval = rand_f();
    tval = rand_t();
    start = 1'b1;
    dummy_len = model_frame(mode, fval, tval);
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 0;
    while (xfer_cnt < 5 && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("reset_point", 64'(xfer_cnt), 64'(5));
    done_seen = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 64'(tx_if.tx_valid), 64'(0));
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_data", 64'(tx_if.tx_data), 64'(0));
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("midrst_no_done", 64'(done_seen), 64'(0));
    run_frame(2'b11, rand_f(), rand_t(), 1'b0, 1'b0);

    for (int n = 0; n < 6; n++)
      run_frame(2'($urandom_range(0, 3)), rand_f(), rand_t(), 1'($urandom_range(0, 1)), 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
